// File: rtl/control_suma_teclado.sv
// rtl/control_suma_teclado.sv - keypad-to-adder controller: collects two decimal operands,
// launches the shared adder with a start/done handshake, captures the sum and selects the display value.
module control_suma_teclado #(
  parameter int NDIG    = 3,
  parameter int W       = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_key_valid,
  input  logic [3:0]   i_key_code,
  output logic         o_sum_start,
  output logic [W-1:0] o_sum_a,
  output logic [W-1:0] o_sum_b,
  input  logic         i_sum_done,
  input  logic [W:0]   i_sum_result,
  output logic [W:0]   o_result,
  output logic         o_result_valid,
  output logic         o_err,
  output logic [1:0]   o_disp_sel,
  output logic [W:0]   o_disp_value,
  output logic [1:0]   o_state
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NDIG);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    KEY_ENTER = 4'hA;
  localparam logic [3:0]    KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {
    S_ENTER_A  = 2'd0,
    S_ENTER_B  = 2'd1,
    S_WAIT_SUM = 2'd2,
    S_SHOW     = 2'd3
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_op_a;
  logic [W-1:0]  r_op_b;
  logic [W:0]    r_result;
  logic [CW-1:0] r_digit_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_sum_start;
  logic          r_result_valid;
  logic          r_err;
  logic [1:0]    r_disp_sel;

  logic          w_key_digit;
  logic          w_key_enter;
  logic          w_key_clear;
  logic          w_digit_room;
  logic [W-1:0]  w_digit;
  logic [W-1:0]  w_acc_src;
  logic [W-1:0]  w_acc_next;

  assign w_key_digit  = i_key_valid && (i_key_code <= 4'd9);
  assign w_key_enter  = i_key_valid && (i_key_code == KEY_ENTER);
  assign w_key_clear  = i_key_valid && (i_key_code == KEY_CLEAR);
  assign w_digit_room = (r_digit_cnt < CNT_MAX);
  assign w_digit      = {{(W-4){1'b0}}, i_key_code};
  assign w_acc_src    = (r_state == S_ENTER_B) ? r_op_b : r_op_a;
  // op*10 + d without a multiplier
  assign w_acc_next   = (w_acc_src << 3) + (w_acc_src << 1) + w_digit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_ENTER_A;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_result       <= '0;
      r_digit_cnt    <= '0;
      r_tmo_cnt      <= '0;
      r_sum_start    <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_disp_sel     <= 2'd0;
    end else begin
      r_sum_start <= 1'b0;
      case (r_state)
        S_ENTER_A: begin
          r_disp_sel <= 2'd0;
          if (w_key_digit) begin
            if (w_digit_room) begin
              r_op_a      <= w_acc_next;
              r_digit_cnt <= r_digit_cnt + CW'(1);
            end
          end else if (w_key_enter) begin
            if (r_digit_cnt == '0) begin
              r_op_a <= '0;
            end
            r_digit_cnt <= '0;
            r_disp_sel  <= 2'd1;
            r_state     <= S_ENTER_B;
          end else if (w_key_clear) begin
            r_op_a      <= '0;
            r_digit_cnt <= '0;
          end
        end

        S_ENTER_B: begin
          if (w_key_digit) begin
            if (w_digit_room) begin
              r_op_b      <= w_acc_next;
              r_digit_cnt <= r_digit_cnt + CW'(1);
            end
          end else if (w_key_enter) begin
            r_sum_start <= 1'b1;
            r_tmo_cnt   <= '0;
            r_state     <= S_WAIT_SUM;
          end else if (w_key_clear) begin
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_digit_cnt    <= '0;
            r_disp_sel     <= 2'd0;
            r_state        <= S_ENTER_A;
          end
        end

        S_WAIT_SUM: begin
          // keys are dropped here; done has priority over the timeout
          if (i_sum_done) begin
            r_result       <= i_sum_result;
            r_result_valid <= 1'b1;
            r_err          <= 1'b0;
            r_disp_sel     <= 2'd2;
            r_state        <= S_SHOW;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b1;
            r_disp_sel     <= 2'd0;
            r_state        <= S_SHOW;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end

        S_SHOW: begin
          if (w_key_clear || w_key_digit) begin
            r_op_a         <= w_key_digit ? w_digit : '0;
            r_digit_cnt    <= w_key_digit ? CW'(1) : '0;
            r_op_b         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_disp_sel     <= 2'd0;
            r_state        <= S_ENTER_A;
          end
        end

        default: r_state <= S_ENTER_A;
      endcase
    end
  end

  always_comb begin
    o_disp_value = '0;
    case (r_disp_sel)
      2'd0:    o_disp_value = {1'b0, r_op_a};
      2'd1:    o_disp_value = {1'b0, r_op_b};
      2'd2:    o_disp_value = r_result;
      default: o_disp_value = '0;
    endcase
  end

  assign o_sum_start    = r_sum_start;
  assign o_sum_a        = r_op_a;
  assign o_sum_b        = r_op_b;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_err          = r_err;
  assign o_disp_sel     = r_disp_sel;
  assign o_state        = r_state;

endmodule
